// File: rtl/config_frame_loader_if.sv
// Serial frame input and latch-array drive bundle for config_frame_loader.
interface config_frame_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WL     = 16
);
  logic                  enable;
  logic                  din;
  logic                  din_valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] bl;
  logic [NUM_WL-1:0]     wl;
  logic                  err;
  logic [7:0]            frame_cnt;

  modport master (
    output enable, din, din_valid,
    input  ready, bl, wl, err, frame_cnt
  );

  modport slave (
    input  enable, din, din_valid,
    output ready, bl, wl, err, frame_cnt
  );
endinterface

// File: rtl/config_frame_loader.sv
// Serial configuration frame loader driving latch bit-lines and one-hot word-lines.
// Define CONFIG_FRAME_LOADER_PARITY_EN to append and check an even-parity bit per frame.
module config_frame_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_WL     = 16
) (
  input  logic clk,
  input  logic rst_n,
  config_frame_loader_if.slave bus
);

`ifdef CONFIG_FRAME_LOADER_PARITY_EN
  localparam int FRAME_LEN = ADDR_WIDTH + DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = ADDR_WIDTH + DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH:0] NUM_WL_LIM = (ADDR_WIDTH + 1)'(NUM_WL);

  typedef enum logic [2:0] {IDLE, SHIFT, DRIVE, WRITE, HOLD} state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    run;
  logic                    ready;
  logic                    accept;
  logic                    last_bit;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_LEN-2:0]    shift_reg;
  logic [FRAME_LEN-1:0]    frame;
  logic [ADDR_WIDTH-1:0]   frame_addr;
  logic [DATA_WIDTH-1:0]   frame_data;
  logic                    frame_ok;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_ok_q;
  logic [DATA_WIDTH-1:0]   bl_q;
  logic                    err_q;
  logic [7:0]              cnt_q;
  logic [NUM_WL-1:0]       wl;

  // Reset assertion is immediate; release takes effect one edge later so the
  // first state change lands on the second rising edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign accept     = ready & bus.din_valid;
  assign last_bit   = accept && (bit_cnt == LAST_BIT);
  assign frame      = {shift_reg, bus.din};
  assign frame_addr = frame[FRAME_LEN-1 -: ADDR_WIDTH];

`ifdef CONFIG_FRAME_LOADER_PARITY_EN
  assign frame_data = frame[DATA_WIDTH:1];
  assign frame_ok   = ({1'b0, frame_addr} < NUM_WL_LIM) && ~(^frame);
`else
  assign frame_data = frame[DATA_WIDTH-1:0];
  assign frame_ok   = ({1'b0, frame_addr} < NUM_WL_LIM);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (run) state <= state_next;
  end

  // Dropping enable removes ready in the same cycle, so a partial frame can
  // never complete on the way back to IDLE.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE:  if (bus.enable) state_next = SHIFT;
      SHIFT: begin
        ready = bus.enable;
        if (!bus.enable)   state_next = IDLE;
        else if (last_bit) state_next = DRIVE;
      end
      DRIVE: state_next = WRITE;
      WRITE: state_next = HOLD;
      HOLD:  state_next = bus.enable ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      addr_q     <= '0;
      write_ok_q <= 1'b0;
      bl_q       <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else if (run) begin
      if (state != SHIFT)
        bit_cnt <= '0;
      else if (accept)
        bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      if (accept)
        shift_reg <= frame[FRAME_LEN-2:0];
      if (last_bit) begin
        addr_q     <= frame_addr;
        write_ok_q <= frame_ok;
        bl_q       <= frame_data;
      end
      if (state == WRITE) begin
        if (!write_ok_q)       err_q <= 1'b1;
        else if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Decoded straight from the state register so an asynchronous reset
  // drops the word line without waiting for a clock edge.
  always_comb begin
    wl = '0;
    for (int i = 0; i < NUM_WL; i++)
      wl[i] = (state == WRITE) && write_ok_q && (addr_q == ADDR_WIDTH'(i));
  end

  assign bus.ready     = ready;
  assign bus.bl        = bl_q;
  assign bus.wl        = wl;
  assign bus.err       = err_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: a 16-word-line and a 12-word-line
// instance share one serial stimulus stream.
module tb_config_frame_loader;

`ifdef CONFIG_FRAME_LOADER_PARITY_EN
  localparam int FL = 13;
`else
  localparam int FL = 12;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int c16 = 0;
  int c12 = 0;
  logic e16 = 1'b0;
  logic e12 = 1'b0;

  config_frame_loader_if #(.DATA_WIDTH(8), .NUM_WL(16)) bus16 ();
  config_frame_loader_if #(.DATA_WIDTH(8), .NUM_WL(12)) bus12 ();

  assign bus16.enable    = enable;
  assign bus16.din       = din;
  assign bus16.din_valid = din_valid;
  assign bus12.enable    = enable;
  assign bus12.din       = din;
  assign bus12.din_valid = din_valid;

  config_frame_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_WL(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  config_frame_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_WL(12)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus12)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitReady();
    int n = 0;
    while (!bus16.ready && n < 40) begin
      tick();
      n++;
    end
    if (!bus16.ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout observed=0 expected=1");
    end
  endtask

  // Shifts one frame MSB first; gap inserts an idle cycle before every bit.
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data,
                               input bit gap, input bit bad_par);
    logic [FL-1:0] f;
`ifdef CONFIG_FRAME_LOADER_PARITY_EN
    f = {addr, data, (^{addr, data}) ^ bad_par};
`else
    f = {addr, data};
    if (bad_par) f = {addr, data};
`endif
    for (int i = FL - 1; i >= 0; i--) begin
      if (gap) begin
        din_valid = 1'b0;
        tick();
      end
      din = f[i];
      din_valid = 1'b1;
      waitReady();
      tick();
    end
  endtask

  // Called one step after the edge that took the last bit (cycle N+1).
  task automatic checkWrite(input logic [7:0] exp_bl, input logic [15:0] exp_wl16,
                            input logic [11:0] exp_wl12, input bit hold_valid);
    din_valid = hold_valid;
    din = 1'b1;
    checkOutput("drive_ready", 32'(bus16.ready), 32'h0);
    checkOutput("drive_bl", 32'(bus16.bl), 32'(exp_bl));
    checkOutput("drive_wl", 32'(bus16.wl), 32'h0);
    tick();
    checkOutput("write_wl16", 32'(bus16.wl), 32'(exp_wl16));
    checkOutput("write_wl12", 32'(bus12.wl), 32'(exp_wl12));
    checkOutput("write_bl", 32'(bus16.bl), 32'(exp_bl));
    tick();
    checkOutput("hold_wl16", 32'(bus16.wl), 32'h0);
    checkOutput("hold_wl12", 32'(bus12.wl), 32'h0);
    checkOutput("hold_ready", 32'(bus16.ready), 32'h0);
    checkOutput("cnt16", 32'(bus16.frame_cnt), 32'(c16));
    checkOutput("cnt12", 32'(bus12.frame_cnt), 32'(c12));
    checkOutput("err16", 32'(bus16.err), 32'(e16));
    checkOutput("err12", 32'(bus12.err), 32'(e12));
    tick();
    checkOutput("turnaround_ready", 32'(bus16.ready), 32'h1);
    din_valid = 1'b0;
  endtask

  task automatic releaseReset();
    tick();
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
    checkOutput("sync_ready_e1", 32'(bus16.ready), 32'h0);
    tick();
    checkOutput("sync_ready_e2", 32'(bus16.ready), 32'h1);
  endtask

  initial begin
    logic [5:0] partial;
    partial = 6'b101101;

    tick();
    tick();
    checkOutput("rst_ready", 32'(bus16.ready), 32'h0);
    checkOutput("rst_bl", 32'(bus16.bl), 32'h0);
    checkOutput("rst_wl", 32'(bus16.wl), 32'h0);
    checkOutput("rst_err", 32'(bus16.err), 32'h0);
    checkOutput("rst_cnt", 32'(bus16.frame_cnt), 32'h0);
    releaseReset();

    c16 = 1; c12 = 1;
    applyStimulus(4'h3, 8'hA5, 1'b0, 1'b0);
    checkWrite(8'hA5, 16'h0008, 12'h008, 1'b0);

    c16 = 2; e12 = 1'b1;
    applyStimulus(4'hD, 8'hFF, 1'b0, 1'b0);
    checkWrite(8'hFF, 16'h2000, 12'h000, 1'b1);

    c16 = 3; c12 = 2;
    applyStimulus(4'h5, 8'h5A, 1'b1, 1'b0);
    checkWrite(8'h5A, 16'h0020, 12'h020, 1'b1);

    for (int i = 5; i >= 0; i--) begin
      din = partial[i];
      din_valid = 1'b1;
      waitReady();
      tick();
    end
    din_valid = 1'b0;
    enable = 1'b0;
    tick();
    checkOutput("abort_ready", 32'(bus16.ready), 32'h0);
    tick();
    checkOutput("abort_wl", 32'(bus16.wl), 32'h0);
    checkOutput("abort_bl", 32'(bus16.bl), 32'h5A);
    enable = 1'b1;
    tick();
    checkOutput("reenable_ready", 32'(bus16.ready), 32'h1);
    c16 = 4; c12 = 3;
    applyStimulus(4'h0, 8'h3C, 1'b0, 1'b0);
    checkWrite(8'h3C, 16'h0001, 12'h001, 1'b0);

`ifdef CONFIG_FRAME_LOADER_PARITY_EN
    e16 = 1'b1;
    applyStimulus(4'h1, 8'h01, 1'b0, 1'b1);
    checkWrite(8'h01, 16'h0000, 12'h000, 1'b0);
    c16 = 5; c12 = 4;
    applyStimulus(4'h1, 8'h01, 1'b0, 1'b0);
    checkWrite(8'h01, 16'h0002, 12'h002, 1'b0);
`endif

    applyStimulus(4'h7, 8'h11, 1'b0, 1'b0);
    din_valid = 1'b0;
    tick();
    checkOutput("prereset_wl", 32'(bus16.wl), 32'h0080);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_wl", 32'(bus16.wl), 32'h0);
    checkOutput("async_bl", 32'(bus16.bl), 32'h0);
    checkOutput("async_ready", 32'(bus16.ready), 32'h0);
    checkOutput("async_err", 32'(bus16.err), 32'h0);
    checkOutput("async_cnt", 32'(bus16.frame_cnt), 32'h0);
    checkOutput("async_err12", 32'(bus12.err), 32'h0);
    c16 = 0; c12 = 0; e16 = 1'b0; e12 = 1'b0;
    releaseReset();

    for (int i = 0; i < 254; i++)
      applyStimulus(4'(i % 12), 8'(i), 1'b0, 1'b0);
    c16 = 255; c12 = 255;
    applyStimulus(4'h2, 8'hFE, 1'b0, 1'b0);
    checkWrite(8'hFE, 16'h0004, 12'h004, 1'b0);
    applyStimulus(4'h3, 8'hFF, 1'b0, 1'b0);
    checkWrite(8'hFF, 16'h0008, 12'h008, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_frame_loader.md
CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bit-line width, i.e. configuration latches written per frame.
REQ-002 Parameter ADDR_WIDTH, default 4: frame address field width.
REQ-003 Parameter NUM_WL, default 16: number of word lines; 1 <= NUM_WL <= 2**ADDR_WIDTH.
REQ-004 CK  in  1  single clock; all state changes on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 ENABLE  in  1  loader enable; 0 stops frame acceptance.
REQ-007 DIN  in  1  serial frame bit.
REQ-008 DIN_VALID  in  1  DIN qualifier.
REQ-009 READY  out  1  loader accepts a bit this cycle.
REQ-010 BL  out  DATA_WIDTH  bit-line data to latch D inputs.
REQ-011 WL  out  NUM_WL  one-hot word-line write enables to latch WE inputs.
REQ-012 ERR  out  1  sticky frame-error flag.
REQ-013 FRAME_CNT  out  8  count of frames written, saturating.

Function
REQ-014 Bit accepted only on a cycle with DIN_VALID=1 and READY=1; DIN_VALID while READY=0 is ignored, not buffered.
REQ-015 Frame of L = ADDR_WIDTH+DATA_WIDTH bits (L+1 with parity, REQ-030): address MSB first, then data MSB first.
REQ-016 FSM states IDLE, SHIFT, DRIVE, WRITE, HOLD; READY=1 only in SHIFT.
REQ-017 IDLE -> SHIFT on the cycle after ENABLE=1; bit counter cleared.
REQ-018 SHIFT -> DRIVE on the edge accepting the last frame bit; otherwise stays in SHIFT.
REQ-019 DRIVE: BL = captured data, WL all 0 (one-cycle setup); -> WRITE.
REQ-020 WRITE: WL[addr]=1 for exactly one cycle, BL unchanged; -> HOLD.
REQ-021 HOLD: WL all 0, BL unchanged (one-cycle hold); -> SHIFT if ENABLE=1, else IDLE.
REQ-022 Bit-to-bit turnaround: last bit accepted at edge N -> WL pulse in cycle N+2 -> READY=1 again in cycle N+4.
REQ-023 Address >= NUM_WL: WRITE asserts no WL bit, ERR set, FRAME_CNT unchanged.
REQ-024 FRAME_CNT increments by 1 on every WRITE with a WL pulse; holds at 255, no wrap.
REQ-025 ENABLE=0 in SHIFT: partial frame discarded, -> IDLE next cycle; ENABLE=0 in DRIVE/WRITE/HOLD: write completes, then IDLE.
REQ-026 BL retains its last value in IDLE and SHIFT; WL is never multi-hot.
REQ-027 ERR is cleared only by reset.

Reset
REQ-028 RST=0 asynchronously forces state IDLE, bit counter 0, shift register 0, BL=0, WL=0, READY=0, ERR=0, FRAME_CNT=0, including mid-WRITE (WL drops without waiting for CK).
REQ-029 Release of RST synchronised internally; first state change on the second rising CK after RST rises.

Configuration
REQ-030 Macro CONFIG_FRAME_LOADER_PARITY_EN defined: frame carries one trailing even-parity bit (ones across address, data and parity is even); on mismatch WRITE asserts no WL, ERR set, FRAME_CNT unchanged.
REQ-031 Macro undefined: no parity bit, frame length exactly L, no parity logic present.

Verification
REQ-032 Defaults, no parity: ENABLE=1, stream addr 0x3 + data 0xA5 continuously -> BL=0xA5 from cycle N+1, WL=0x0008 for exactly cycle N+2, FRAME_CNT=1, READY high again at N+4.
REQ-033 NUM_WL=12, frame addr 0xD + data 0xFF -> WL stays 0, ERR=1, FRAME_CNT=0, following valid frame still written.
REQ-034 Parity enabled: frame addr 0x1, data 0x01, parity 1 -> ERR=1, no WL pulse; same frame with parity 0 -> WL=0x0002.
REQ-035 DIN_VALID toggling every other cycle plus DIN_VALID held high during DRIVE/WRITE/HOLD -> exactly 12 bits captured per frame, extra bits ignored.
REQ-036 ENABLE dropped after 6 bits -> IDLE, no WL; re-enable and full frame addr 0x0 data 0x3C -> WL=0x0001, BL=0x3C; RST asserted during WRITE -> WL=0 immediately, all outputs at reset values.
REQ-037 256 valid frames -> FRAME_CNT=255 after the 255th frame and stays 255 after the 256th.
